// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 receiver state encoding, frame constants and parity helper
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_t;

  localparam int FRAME_LEN = 11;
  localparam int DATA_W    = 8;
  // Bits collected after the start bit: 8 data, parity, stop.
  localparam int RECV_BITS = FRAME_LEN - 1;

  // PS/2 uses odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [DATA_W-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_fifo.sv
// rtl/ps2_sync_fifo.sv - show-ahead synchronous FIFO with overflow pulse
module ps2_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_pop_data,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_wr;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_pop && !w_empty;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_wr    = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= i_push && w_full && !w_pop;
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_valid    = !w_empty;
  assign o_pop_data = w_empty ? '0 : r_mem[r_rptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver: synchroniser, clock filter, frame FSM, receive FIFO
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          kbclk,
  input  logic                          kbdat,
  input  logic                          rd_ready,
  output logic                          rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          timeout_err,
  output logic                          overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BCW = $clog2(RECV_BITS + 1);

  logic [1:0]           r_clk_sync;
  logic [1:0]           r_dat_sync;
  logic                 r_clk_filt;
  logic                 r_clk_prev;
  logic [FCW-1:0]       r_filt_cnt;
  ps2_state_t           r_state;
  logic [BCW-1:0]       r_bit_cnt;
  logic [TW-1:0]        r_timer;
  logic [RECV_BITS-1:0] r_frame;
  logic                 r_parity_err;
  logic                 r_frame_err;
  logic                 r_timeout_err;

  logic                 w_clk_s;
  logic                 w_dat_s;
  logic                 w_fall;
  logic                 w_stop;
  logic                 w_par_ok;
  logic                 w_push;

  // Synchronisers reset to 1 so the bus looks idle coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], kbclk};
      r_dat_sync <= {r_dat_sync[0], kbdat};
    end
  end

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  // The filtered clock follows only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_filt <= 1'b1;
      r_clk_prev <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_prev <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (int'(r_filt_cnt) >= FILTER_LEN - 1) begin
        r_clk_filt <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  assign w_fall   = r_clk_prev && !r_clk_filt;
  assign w_stop   = r_frame[RECV_BITS-1];
  assign w_par_ok = odd_parity_ok(r_frame[DATA_W-1:0], r_frame[DATA_W]);
  assign w_push   = (r_state == ST_CHECK) && w_stop && w_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_timer       <= '0;
      r_frame       <= '0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall && !w_dat_s) begin
            r_state   <= ST_RECV;
            r_bit_cnt <= '0;
            r_timer   <= '0;
          end
        end
        ST_RECV: begin
          if (w_fall) begin
            // LSB-first: each new bit enters at the top and shifts toward bit 0.
            r_frame   <= {w_dat_s, r_frame[RECV_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_timer   <= '0;
            if (r_bit_cnt == BCW'(RECV_BITS - 1)) begin
              r_state <= ST_CHECK;
            end
          end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_IDLE;
            r_bit_cnt     <= '0;
            r_timer       <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_CHECK: begin
          if (!w_stop) begin
            r_frame_err <= 1'b1;
          end else if (!w_par_ok) begin
            r_parity_err <= 1'b1;
          end
          r_state   <= ST_IDLE;
          r_bit_cnt <= '0;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_frame[DATA_W-1:0]),
    .i_pop       (rd_ready),
    .o_pop_data  (rd_data),
    .o_valid     (rd_valid),
    .o_count     (fifo_count),
    .o_overflow  (overflow)
  );

  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign timeout_err = r_timeout_err;

endmodule
